// File: rtl/sram_rgb_frame_writer.sv
// Collects RGB pixels four at a time and writes each group to SRAM as six
// 16-bit words: two red, two green, one even-blue and one odd-blue word.
module sram_rgb_frame_writer #(
    parameter int          NUM_PIXELS              = 76800,
    parameter logic [17:0] RED_START_ADDRESS       = 18'd0,
    parameter logic [17:0] GREEN_START_ADDRESS     = 18'd38400,
    parameter logic [17:0] BLUE_EVEN_START_ADDRESS = 18'd76800,
    parameter logic [17:0] BLUE_ODD_START_ADDRESS  = 18'd96000
) (
    input  logic        Clock_50,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Pixel_valid,
    output logic        Pixel_ready,
    input  logic [7:0]  Pixel_R,
    input  logic [7:0]  Pixel_G,
    input  logic [7:0]  Pixel_B,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        Busy,
    output logic        Done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_WR_R0   = 3'd2;
    localparam logic [2:0] S_WR_R1   = 3'd3;
    localparam logic [2:0] S_WR_G0   = 3'd4;
    localparam logic [2:0] S_WR_G1   = 3'd5;
    localparam logic [2:0] S_WR_BE   = 3'd6;
    localparam logic [2:0] S_WR_BO   = 3'd7;

    localparam logic [17:0] LAST_GROUP = 18'(NUM_PIXELS / 4 - 1);

    logic [2:0]  state_q, state_d;
    logic [17:0] g_q, g_d;
    logic [1:0]  p_q, p_d;
    logic [7:0]  r_q [4];
    logic [7:0]  r_d [4];
    logic [7:0]  gr_q [4];
    logic [7:0]  gr_d [4];
    logic [7:0]  b_q [4];
    logic [7:0]  b_d [4];
    logic [17:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        we_n_q, we_n_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [17:0] g_x2;

    assign g_x2 = {g_q[16:0], 1'b0};

    // State names the word currently presented on the SRAM outputs; each
    // transition loads the next word so every output stays registered.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        p_d     = p_q;
        r_d     = r_q;
        gr_d    = gr_q;
        b_d     = b_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_n_d  = 1'b1;
        ready_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_COLLECT;
                    busy_d  = 1'b1;
                    g_d     = '0;
                    p_d     = '0;
                    ready_d = 1'b1;
                end
            end
            S_COLLECT: begin
                ready_d = 1'b1;
                if (Pixel_valid && ready_q) begin
                    r_d[p_q]  = Pixel_R;
                    gr_d[p_q] = Pixel_G;
                    b_d[p_q]  = Pixel_B;
                    if (p_q == 2'd3) begin
                        // Slots 0 and 1 are already stored, so R0 needs no bypass.
                        state_d = S_WR_R0;
                        p_d     = '0;
                        ready_d = 1'b0;
                        we_n_d  = 1'b0;
                        addr_d  = RED_START_ADDRESS + g_x2;
                        data_d  = {r_q[0], r_q[1]};
                    end else begin
                        p_d = p_q + 2'd1;
                    end
                end
            end
            S_WR_R0: begin
                state_d = S_WR_R1;
                we_n_d  = 1'b0;
                addr_d  = RED_START_ADDRESS + g_x2 + 18'd1;
                data_d  = {r_q[2], r_q[3]};
            end
            S_WR_R1: begin
                state_d = S_WR_G0;
                we_n_d  = 1'b0;
                addr_d  = GREEN_START_ADDRESS + g_x2;
                data_d  = {gr_q[0], gr_q[1]};
            end
            S_WR_G0: begin
                state_d = S_WR_G1;
                we_n_d  = 1'b0;
                addr_d  = GREEN_START_ADDRESS + g_x2 + 18'd1;
                data_d  = {gr_q[2], gr_q[3]};
            end
            S_WR_G1: begin
                state_d = S_WR_BE;
                we_n_d  = 1'b0;
                addr_d  = BLUE_EVEN_START_ADDRESS + g_q;
                data_d  = {b_q[0], b_q[2]};
            end
            S_WR_BE: begin
                state_d = S_WR_BO;
                we_n_d  = 1'b0;
                addr_d  = BLUE_ODD_START_ADDRESS + g_q;
                data_d  = {b_q[1], b_q[3]};
            end
            S_WR_BO: begin
                if (g_q == LAST_GROUP) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_COLLECT;
                    g_d     = g_q + 18'd1;
                    ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            p_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_q[i]  <= '0;
                gr_q[i] <= '0;
                b_q[i]  <= '0;
            end
            addr_q  <= '0;
            data_q  <= '0;
            we_n_q  <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            p_q     <= p_d;
            r_q     <= r_d;
            gr_q    <= gr_d;
            b_q     <= b_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_n_q  <= we_n_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Pixel_ready     = ready_q;
    assign SRAM_address    = addr_q;
    assign SRAM_write_data = data_q;
    assign SRAM_we_n       = we_n_q;
    assign Busy            = busy_q;
    assign Done            = done_q;

endmodule

// File: tb/tb_sram_rgb_frame_writer.sv
// Directed bench for sram_rgb_frame_writer using a reduced 32-pixel frame
// so full-frame, gap and mid-frame reset scenarios stay short.
module tb_sram_rgb_frame_writer;

    localparam int          NPIX = 32;
    localparam int          NG   = NPIX / 4;
    localparam logic [17:0] RED  = 18'd0;
    localparam logic [17:0] GRN  = 18'd38400;
    localparam logic [17:0] BEV  = 18'd76800;
    localparam logic [17:0] BOD  = 18'd96000;

    logic        Clock_50 = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Pixel_valid = 1'b0;
    logic        Pixel_ready;
    logic [7:0]  Pixel_R = '0;
    logic [7:0]  Pixel_G = '0;
    logic [7:0]  Pixel_B = '0;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        Busy;
    logic        Done;

    int n_cmp = 0;
    int n_fail = 0;

    sram_rgb_frame_writer #(
        .NUM_PIXELS              (NPIX),
        .RED_START_ADDRESS       (RED),
        .GREEN_START_ADDRESS     (GRN),
        .BLUE_EVEN_START_ADDRESS (BEV),
        .BLUE_ODD_START_ADDRESS  (BOD)
    ) dut (
        .Clock_50        (Clock_50),
        .Reset           (Reset),
        .Start           (Start),
        .Pixel_valid     (Pixel_valid),
        .Pixel_ready     (Pixel_ready),
        .Pixel_R         (Pixel_R),
        .Pixel_G         (Pixel_G),
        .Pixel_B         (Pixel_B),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .Busy            (Busy),
        .Done            (Done)
    );

    always #10 Clock_50 = ~Clock_50;

    // Write log and event monitor, sampled on the falling edge.
    logic [17:0] log_a [$];
    logic [15:0] log_d [$];
    logic [17:0] exp_a [$];
    logic [15:0] exp_d [$];
    int   done_cnt = 0;
    int   hs_cnt = 0;
    logic done_busy = 1'b1;
    logic done_prev_busy = 1'b0;
    logic done_prev_we = 1'b1;
    logic prev_busy = 1'b0;
    logic prev_we = 1'b1;
    bit   spec_pat = 1'b0;

    always @(negedge Clock_50) begin
        if (SRAM_we_n === 1'b0) begin
            log_a.push_back(SRAM_address);
            log_d.push_back(SRAM_write_data);
        end
        if (Pixel_valid && Pixel_ready) hs_cnt++;
        if (Done === 1'b1) begin
            done_cnt++;
            done_busy      = Busy;
            done_prev_busy = prev_busy;
            done_prev_we   = prev_we;
        end
        prev_busy = Busy;
        prev_we   = SRAM_we_n;
    end

    function automatic logic [7:0] pr(input int n);
        return spec_pat ? 8'(10 + n) : 8'(n);
    endfunction
    function automatic logic [7:0] pg(input int n);
        return spec_pat ? 8'(20 + n) : 8'(n * 3 + 7);
    endfunction
    function automatic logic [7:0] pb(input int n);
        return spec_pat ? 8'(30 + n) : 8'(200 - n);
    endfunction

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
        done_cnt = 0;
        hs_cnt = 0;
    endtask

    task automatic build_expected(input int first, input int ngroups);
        exp_a.delete();
        exp_d.delete();
        for (int g = 0; g < ngroups; g++) begin
            int b = first + 4 * g;
            exp_a.push_back(RED + 18'(2 * g));     exp_d.push_back({pr(b),     pr(b + 1)});
            exp_a.push_back(RED + 18'(2 * g + 1)); exp_d.push_back({pr(b + 2), pr(b + 3)});
            exp_a.push_back(GRN + 18'(2 * g));     exp_d.push_back({pg(b),     pg(b + 1)});
            exp_a.push_back(GRN + 18'(2 * g + 1)); exp_d.push_back({pg(b + 2), pg(b + 3)});
            exp_a.push_back(BEV + 18'(g));         exp_d.push_back({pb(b),     pb(b + 2)});
            exp_a.push_back(BOD + 18'(g));         exp_d.push_back({pb(b + 1), pb(b + 3)});
        end
    endtask

    task automatic step();
        @(posedge Clock_50);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Start = 1'b0;
        Pixel_valid = 1'b0;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    // Feeds count pixels; returns #1 after the edge that captured the last one.
    task automatic send_pix(input int first, input int count, input int gap_pct, input bit start_noise);
        int idx = 0;
        int cyc = 0;
        bit hs;
        while (idx < count) begin
            Pixel_valid = (gap_pct == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
            Pixel_R = pr(first + idx);
            Pixel_G = pg(first + idx);
            Pixel_B = pb(first + idx);
            Start = start_noise && ($urandom_range(9) == 0);
            @(negedge Clock_50);
            hs = Pixel_valid && Pixel_ready;
            step();
            if (hs) idx++;
            cyc++;
            if (cyc > count * 40 + 100) begin
                n_cmp++; n_fail++;
                $display("FAIL send_timeout: accepted %0d required %0d", idx, count);
                break;
            end
        end
        Pixel_valid = 1'b0;
        Start = 1'b0;
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (done_cnt == 0 && cyc < 40) begin
            step();
            cyc++;
        end
        n_cmp++;
        if (done_cnt == 0) begin
            n_fail++;
            $display("FAIL done_timeout: done_cnt %0d required >=1", done_cnt);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        n_cmp += 6;
        if (SRAM_we_n !== 1'b1)        begin n_fail++; $display("FAIL rst_we_n: got %b exp 1", SRAM_we_n); end
        if (SRAM_address !== 18'd0)    begin n_fail++; $display("FAIL rst_addr: got %0d exp 0", SRAM_address); end
        if (SRAM_write_data !== 16'd0) begin n_fail++; $display("FAIL rst_data: got %h exp 0000", SRAM_write_data); end
        if (Pixel_ready !== 1'b0)      begin n_fail++; $display("FAIL rst_ready: got %b exp 0", Pixel_ready); end
        if (Busy !== 1'b0)             begin n_fail++; $display("FAIL rst_busy: got %b exp 0", Busy); end
        if (Done !== 1'b0)             begin n_fail++; $display("FAIL rst_done: got %b exp 0", Done); end
        Reset = 1'b0;
        $display("test_reset: done, %0d compared so far", n_cmp);
    endtask

    task automatic test_idle_valid();
        clear_log();
        Pixel_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (Pixel_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: cycle %0d got %b exp 0", i, Pixel_ready); end
        end
        Pixel_valid = 1'b0;
        n_cmp++;
        if (log_a.size() != 0) begin n_fail++; $display("FAIL idle_writes: got %0d exp 0", log_a.size()); end
        $display("test_idle_valid: done, %0d compared so far", n_cmp);
    endtask

    task automatic test_single_group();
        logic [17:0] ea [6];
        logic [15:0] ed [6];
        ea = '{18'd0, 18'd1, 18'd38400, 18'd38401, 18'd76800, 18'd96000};
        ed = '{16'h0A0B, 16'h0C0D, 16'h1415, 16'h1617, 16'h1E20, 16'h1F21};
        do_reset();
        clear_log();
        spec_pat = 1'b1;
        pulse_start();
        n_cmp += 2;
        if (Busy !== 1'b1)        begin n_fail++; $display("FAIL start_busy: got %b exp 1", Busy); end
        if (Pixel_ready !== 1'b1) begin n_fail++; $display("FAIL start_ready: got %b exp 1", Pixel_ready); end
        send_pix(0, 4, 0, 0);
        for (int i = 0; i < 6; i++) begin
            n_cmp += 4;
            if (SRAM_we_n !== 1'b0)      begin n_fail++; $display("FAIL grp_we_n[%0d]: got %b exp 0", i, SRAM_we_n); end
            if (SRAM_address !== ea[i])  begin n_fail++; $display("FAIL grp_addr[%0d]: got %0d exp %0d", i, SRAM_address, ea[i]); end
            if (SRAM_write_data !== ed[i]) begin n_fail++; $display("FAIL grp_data[%0d]: got %h exp %h", i, SRAM_write_data, ed[i]); end
            if (Pixel_ready !== 1'b0)    begin n_fail++; $display("FAIL grp_ready[%0d]: got %b exp 0", i, Pixel_ready); end
            step();
        end
        n_cmp += 4;
        if (SRAM_we_n !== 1'b1)        begin n_fail++; $display("FAIL grp_end_we_n: got %b exp 1", SRAM_we_n); end
        if (Pixel_ready !== 1'b1)      begin n_fail++; $display("FAIL grp_end_ready: got %b exp 1", Pixel_ready); end
        if (SRAM_write_data !== 16'h1F21) begin n_fail++; $display("FAIL grp_hold_data: got %h exp 1f21", SRAM_write_data); end
        if (Done !== 1'b0)             begin n_fail++; $display("FAIL grp_done: got %b exp 0", Done); end
        spec_pat = 1'b0;
        $display("test_single_group: done, %0d compared so far", n_cmp);
    endtask

    task automatic test_full_frame();
        do_reset();
        clear_log();
        build_expected(0, NG);
        pulse_start();
        send_pix(0, NPIX, 0, 0);
        wait_done();
        for (int i = 0; i < 4; i++) step();
        n_cmp += 5;
        if (log_a.size() != NG * 6) begin n_fail++; $display("FAIL frame_wr_count: got %0d exp %0d", log_a.size(), NG * 6); end
        if (done_cnt != 1)          begin n_fail++; $display("FAIL frame_done_cnt: got %0d exp 1", done_cnt); end
        if (done_busy !== 1'b0 || done_prev_busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy_fall: busy %b prev %b exp 0/1", done_busy, done_prev_busy); end
        if (done_prev_we !== 1'b0)  begin n_fail++; $display("FAIL frame_done_after_wr: prev we_n %b exp 0", done_prev_we); end
        if (Busy !== 1'b0 || Pixel_ready !== 1'b0) begin n_fail++; $display("FAIL frame_idle: busy %b ready %b exp 0/0", Busy, Pixel_ready); end
        for (int i = 0; i < NG * 6 && i < log_a.size(); i++) begin
            n_cmp++;
            if (log_a[i] !== exp_a[i] || log_d[i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL frame_word[%0d]: got %0d:%h exp %0d:%h", i, log_a[i], log_d[i], exp_a[i], exp_d[i]);
            end
        end
        $display("test_full_frame: done, %0d compared so far", n_cmp);
    endtask

    task automatic test_gaps_and_start_noise();
        do_reset();
        clear_log();
        build_expected(0, NG);
        pulse_start();
        send_pix(0, NPIX, 50, 1);
        wait_done();
        for (int i = 0; i < 4; i++) step();
        n_cmp += 3;
        if (log_a.size() != NG * 6) begin n_fail++; $display("FAIL gap_wr_count: got %0d exp %0d", log_a.size(), NG * 6); end
        if (hs_cnt != NPIX)         begin n_fail++; $display("FAIL gap_handshakes: got %0d exp %0d", hs_cnt, NPIX); end
        if (done_cnt != 1)          begin n_fail++; $display("FAIL gap_done_cnt: got %0d exp 1", done_cnt); end
        for (int i = 0; i < NG * 6 && i < log_a.size(); i++) begin
            n_cmp++;
            if (log_a[i] !== exp_a[i] || log_d[i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL gap_word[%0d]: got %0d:%h exp %0d:%h", i, log_a[i], log_d[i], exp_a[i], exp_d[i]);
            end
        end
        $display("test_gaps_and_start_noise: done, %0d compared so far", n_cmp);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        clear_log();
        pulse_start();
        send_pix(0, 24, 0, 0);
        step();
        step();
        n_cmp++;
        if (SRAM_we_n !== 1'b0 || SRAM_address !== GRN + 18'd10) begin
            n_fail++;
            $display("FAIL mid_g0_pos: got we_n %b addr %0d exp 0/%0d", SRAM_we_n, SRAM_address, GRN + 18'd10);
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        n_cmp += 3;
        if (SRAM_we_n !== 1'b1)     begin n_fail++; $display("FAIL mid_rst_we_n: got %b exp 1", SRAM_we_n); end
        if (Busy !== 1'b0)          begin n_fail++; $display("FAIL mid_rst_busy: got %b exp 0", Busy); end
        if (SRAM_address !== 18'd0) begin n_fail++; $display("FAIL mid_rst_addr: got %0d exp 0", SRAM_address); end
        clear_log();
        pulse_start();
        send_pix(100, 4, 0, 0);
        for (int i = 0; i < 7; i++) step();
        n_cmp += 3;
        if (log_a.size() != 6) begin n_fail++; $display("FAIL restart_count: got %0d exp 6", log_a.size()); end
        if (log_a.size() > 0 && log_a[0] !== 18'd0) begin n_fail++; $display("FAIL restart_addr: got %0d exp 0", log_a[0]); end
        if (log_d.size() > 0 && log_d[0] !== {pr(100), pr(101)}) begin n_fail++; $display("FAIL restart_data: got %h exp %h", log_d[0], {pr(100), pr(101)}); end
        $display("test_reset_mid_burst: done, %0d compared so far", n_cmp);
    endtask

    initial begin
        step();
        test_reset();
        test_idle_valid();
        test_single_group();
        test_full_frame();
        test_gaps_and_start_noise();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_rgb_frame_writer.md
Name: sram_rgb_frame_writer

Overview:
Accepts a stream of 24-bit RGB pixels in raster order and writes them into external SRAM through SRAM_controller. Pixels are stored in the segmented layout the VGA display path reads: packed red and green pairs, with blue split into even and odd segments. This block is the writer side of the SRAM frame-buffer interface. It sits between a pixel source (UART or pattern generator) and SRAM_controller, in place of the built-in rectangle fill.

Parameters:
NUM_PIXELS, 76800, pixels per frame (320x240); must be a multiple of 4
RED_START_ADDRESS, 18'd0, base word address of the red segment
GREEN_START_ADDRESS, 18'd38400, base word address of the green segment
BLUE_EVEN_START_ADDRESS, 18'd76800, base word address of the even-pixel blue segment
BLUE_ODD_START_ADDRESS, 18'd96000, base word address of the odd-pixel blue segment

Ports:
Clock_50  in  1  system clock, 50 MHz
Reset  in  1  synchronous reset, active-high
Start  in  1  one-cycle pulse that begins a frame write
Pixel_valid  in  1  pixel on Pixel_R/G/B is valid
Pixel_ready  out  1  block accepts a pixel this cycle
Pixel_R  in  8  red value
Pixel_G  in  8  green value
Pixel_B  in  8  blue value
SRAM_address  out  18  to SRAM_controller
SRAM_write_data  out  16  to SRAM_controller
SRAM_we_n  out  1  active-low write enable to SRAM_controller
Busy  out  1  frame write in progress
Done  out  1  one-cycle pulse after the last word of the frame is written

Behaviour:
- Interface: one clock (Clock_50). Reset is synchronous and active-high. All outputs are registered.
- Reset values: SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, Pixel_ready=0, Busy=0, Done=0. The group counter and pixel buffer are cleared.
- States: S_IDLE, S_COLLECT, S_WR_R0, S_WR_R1, S_WR_G0, S_WR_G1, S_WR_BE, S_WR_BO.
- S_IDLE:
  - Pixel_ready=0 and Pixel_valid is ignored.
  - Start=1 moves to S_COLLECT, sets Busy=1 and clears group counter g and slot index p.
- S_COLLECT:
  - Pixel_ready=1.
  - A handshake (valid&&ready) stores the pixel in slot p (0..3) and increments p.
  - The handshake that fills slot 3 moves the block to S_WR_R0 and wraps p to 0.
  - Pixel_valid=0 simply holds the state; there is no timeout.
- Write burst: exactly six consecutive cycles with SRAM_we_n=0, one word per cycle, in this order:
  - R0: addr RED_START+2g, data {R0,R1}
  - R1: addr RED_START+2g+1, data {R2,R3}
  - G0: addr GREEN_START+2g, data {G0,G1}
  - G1: addr GREEN_START+2g+1, data {G2,G3}
  - BE: addr BLUE_EVEN_START+g, data {B0,B2}
  - BO: addr BLUE_ODD_START+g, data {B1,B3}
  - The lower-index pixel always goes in bits [15:8].
  - The first write word is on the outputs in the cycle after the edge that captured pixel 3.
  - Pixel_ready=0 throughout the burst.
- Address arithmetic is 18-bit unsigned with no wrap checks; g is 18-bit.
- End of burst:
  - If g==NUM_PIXELS/4-1: SRAM_we_n returns to 1, Done=1 for one cycle, Busy=0, state goes to S_IDLE.
  - Otherwise: g increments, SRAM_we_n returns to 1, state goes to S_COLLECT.
- Throughput: at most 4 pixels per 10 cycles.
- SRAM_address and SRAM_write_data hold their last values when SRAM_we_n=1.
- Start while Busy=1 is ignored.
- Start and Reset in the same cycle: Reset wins.
- Reset at any point (including mid-burst) returns to the reset values on the next edge. The partial group is discarded and not written.
- A new Start after Done rewrites the frame from g=0.

Test Plan:
- Reset, Start, 4 pixels (R,G,B)=(10,20,30),(11,21,31),(12,22,32),(13,23,33) -> six writes on consecutive cycles:
  - 0:0x0A0B
  - 1:0x0C0D
  - 38400:0x1415
  - 38401:0x1617
  - 76800:0x1E20
  - 96000:0x1F21
  - then we_n=1 and Pixel_ready=1.
- Full frame of 76800 pixels with pixel index n giving R=n[7:0] -> exactly 115200 write cycles; last words at 38399, 76799, 96000+19199=115199, 95999; Done pulses once; Busy falls the same cycle.
- Random Pixel_valid gaps (about 50%) -> SRAM contents identical to the gap-free run; no pixel is accepted while Pixel_ready=0.
- Start pulsed mid-frame and during a burst -> no effect on g, the addresses, or the write sequence.
- Reset asserted during write G0 of group 5 -> next cycle we_n=1 and Busy=0; after a new Start, the first write goes to address 0.
- Pixel_valid=1 held in S_IDLE with no Start -> no writes and Pixel_ready=0.
